multicycle_control: RTL and testbench

- Moore FSM control unit for the multicycle MIPS-subset datapath.
- Sequences fetch, decode, execute, memory and writeback, and drives every datapath mux select and register write enable.
- Traps unsupported opcodes and arithmetic overflow to a fixed exception vector.
- Sits beside the datapath. Consumes IR opcode/funct and ALU flags.

---
 rtl/multicycle_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control unit for the multicycle MIPS-subset datapath.
// Steps through fetch, decode, execute, memory and writeback, and drives every
// datapath mux select and write enable. Unsupported opcodes and arithmetic
// overflow on add/sub/addi are trapped to the exception vector, with the cause
// held on exc_cause until the next fetch begins.
module multicycle_control #(
  parameter int MEM_WAIT = 1  // extra cycles after a memory read (0..3)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       PCLoad,
  output logic [2:0] SrcAddressMem,
  output logic       MemOp,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       WriteA,
  output logic       WriteB,
  output logic       WriteALUOut,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [2:0] MemToReg,
  output logic [2:0] RegDst,
  output logic [5:0] state_out,
  output logic [1:0] exc_cause
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Last value of the wait counter before leaving a wait state.
  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);

  typedef enum logic [5:0] {
    RESET  = 6'd0,
    FETCH  = 6'd1,
    FWAIT  = 6'd2,
    IRLOAD = 6'd3,
    DECODE = 6'd4,
    R_EX   = 6'd5,
    R_WB   = 6'd6,
    I_EX   = 6'd7,
    I_WB   = 6'd8,
    ADDR   = 6'd9,
    MREAD  = 6'd10,
    MWAIT  = 6'd11,
    LW_WB  = 6'd12,
    SW     = 6'd13,
    BRANCH = 6'd14,
    JUMP   = 6'd15,
    JR     = 6'd16,
    LUI    = 6'd17,
    EXC    = 6'd18
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [1:0] waitCnt;
  logic       waitDone;
  logic       isAddSub;
  logic       branchTaken;
  logic [2:0] rAluOp;

  assign state_out = state;
  assign waitDone  = (waitCnt == WAIT_LAST);
  assign isAddSub  = (funct == FN_ADD) || (funct == FN_SUB);

  // ALU operation selected by funct for R-type execute.
  always_comb begin
    case (funct)
      FN_SUB:  rAluOp = 3'b010;
      FN_AND:  rAluOp = 3'b011;
      FN_SLT:  rAluOp = 3'b111;
      default: rAluOp = 3'b001;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= RESET;
    else       state <= nextState;
  end

  // Wait-state counter, cleared whenever the FSM is outside a wait state.
  always_ff @(posedge clk) begin
    if (reset || (state != FWAIT && state != MWAIT)) waitCnt <= 2'd0;
    else                                             waitCnt <= waitCnt + 2'd1;
  end

  // Exception cause: latched on entry to EXC, cleared on entry to FETCH.
  always_ff @(posedge clk) begin
    if (reset)                  exc_cause <= 2'd0;
    else if (nextState == FETCH) exc_cause <= 2'd0;
    else if (nextState == EXC)   exc_cause <= (state == DECODE) ? 2'd1 : 2'd2;
  end

  // Next-state logic including opcode dispatch and overflow trapping.
  always_comb begin
    nextState = state;
    case (state)
      RESET:  nextState = FETCH;
      FETCH:  nextState = (MEM_WAIT == 0) ? IRLOAD : FWAIT;
      FWAIT:  nextState = waitDone ? IRLOAD : FWAIT;
      IRLOAD: nextState = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND || funct == FN_SLT)
              nextState = R_EX;
            else if (funct == FN_JR)
              nextState = JR;
            else
              nextState = EXC;
          end
          OP_ADDI:      nextState = I_EX;
          OP_LW, OP_SW: nextState = ADDR;
          OP_BEQ, OP_BNE: nextState = BRANCH;
          OP_LUI:       nextState = LUI;
          OP_J:         nextState = JUMP;
          default:      nextState = EXC;
        endcase
      end
      R_EX:   nextState = (isAddSub && overflow) ? EXC : R_WB;
      I_EX:   nextState = overflow ? EXC : I_WB;
      ADDR:   nextState = (opcode == OP_LW) ? MREAD : SW;
      MREAD:  nextState = (MEM_WAIT == 0) ? LW_WB : MWAIT;
      MWAIT:  nextState = waitDone ? LW_WB : MWAIT;
      R_WB, I_WB, LW_WB, SW, BRANCH, JUMP, JR, LUI, EXC: nextState = FETCH;
      default: nextState = RESET;
    endcase
  end

  // Moore outputs; forced to zero while reset is asserted so no write fires.
  always_comb begin
    PCWrite       = 1'b0;
    SrcAddressMem = 3'd0;
    MemOp         = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    WriteA        = 1'b0;
    WriteB        = 1'b0;
    WriteALUOut   = 1'b0;
    ALUSrcA       = 2'd0;
    ALUSrcB       = 3'd0;
    ALUOp         = 3'b000;
    PCSource      = 2'd0;
    MemToReg      = 3'd0;
    RegDst        = 3'd0;
    branchTaken   = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          ALUSrcB     = 3'd1;
          ALUOp       = 3'b001;
          PCWrite     = 1'b1;
          WriteALUOut = 1'b1;
        end
        FWAIT:  SrcAddressMem = 3'd1;
        IRLOAD: begin
          SrcAddressMem = 3'd1;
          IRWrite       = 1'b1;
        end
        DECODE: begin
          WriteA      = 1'b1;
          WriteB      = 1'b1;
          ALUSrcB     = 3'd3;
          ALUOp       = 3'b001;
          WriteALUOut = 1'b1;
        end
        R_EX: begin
          ALUSrcA     = 2'd1;
          ALUOp       = rAluOp;
          WriteALUOut = 1'b1;
        end
        R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 3'd1;
          MemToReg = (funct == FN_SLT) ? 3'd2 : 3'd0;
        end
        I_EX, ADDR: begin
          ALUSrcA     = 2'd1;
          ALUSrcB     = 3'd2;
          ALUOp       = 3'b001;
          WriteALUOut = 1'b1;
        end
        I_WB:         RegWrite = 1'b1;
        MREAD, MWAIT: SrcAddressMem = 3'd1;
        LW_WB: begin
          MemToReg = 3'd1;
          RegWrite = 1'b1;
        end
        SW: begin
          SrcAddressMem = 3'd1;
          MemOp         = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 2'd1;
          ALUOp       = 3'b010;
          PCSource    = 2'd1;
          branchTaken = (opcode == OP_BNE) ? ~zero : zero;
        end
        JUMP: begin
          PCSource = 2'd2;
          PCWrite  = 1'b1;
        end
        JR: begin
          ALUSrcA = 2'd1;
          PCWrite = 1'b1;
        end
        LUI: begin
          MemToReg = 3'd3;
          RegWrite = 1'b1;
        end
        EXC: begin
          PCSource = 2'd3;
          PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
    PCLoad = PCWrite | branchTaken;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Main instance uses MEM_WAIT=1; a
// second instance with MEM_WAIT=2 checks the wait-state stretching on lw.
module tb_multicycle_control;

  localparam logic [5:0] S_RESET  = 6'd0;
  localparam logic [5:0] S_FETCH  = 6'd1;
  localparam logic [5:0] S_FWAIT  = 6'd2;
  localparam logic [5:0] S_IRLOAD = 6'd3;
  localparam logic [5:0] S_DECODE = 6'd4;
  localparam logic [5:0] S_R_EX   = 6'd5;
  localparam logic [5:0] S_R_WB   = 6'd6;
  localparam logic [5:0] S_I_EX   = 6'd7;
  localparam logic [5:0] S_I_WB   = 6'd8;
  localparam logic [5:0] S_ADDR   = 6'd9;
  localparam logic [5:0] S_MREAD  = 6'd10;
  localparam logic [5:0] S_MWAIT  = 6'd11;
  localparam logic [5:0] S_LW_WB  = 6'd12;
  localparam logic [5:0] S_SW     = 6'd13;
  localparam logic [5:0] S_BRANCH = 6'd14;
  localparam logic [5:0] S_JUMP   = 6'd15;
  localparam logic [5:0] S_JR     = 6'd16;
  localparam logic [5:0] S_LUI    = 6'd17;
  localparam logic [5:0] S_EXC    = 6'd18;

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic [5:0] opcode, funct;
  logic       zero, overflow;

  logic       PCWrite, PCLoad, MemOp, IRWrite, RegWrite, WriteA, WriteB, WriteALUOut;
  logic [2:0] SrcAddressMem, ALUSrcB, ALUOp, MemToReg, RegDst;
  logic [1:0] ALUSrcA, PCSource, exc_cause;
  logic [5:0] state_out;

  logic       d2_PCWrite, d2_PCLoad, d2_MemOp, d2_IRWrite, d2_RegWrite, d2_WriteA, d2_WriteB, d2_WriteALUOut;
  logic [2:0] d2_SrcAddressMem, d2_ALUSrcB, d2_ALUOp, d2_MemToReg, d2_RegDst;
  logic [1:0] d2_ALUSrcA, d2_PCSource, d2_exc_cause;
  logic [5:0] d2_state_out;

  int compared;
  int mismatched;

  // Every control output of the main instance packed together.
  logic [27:0] ctl;
  assign ctl = {PCWrite, PCLoad, SrcAddressMem, MemOp, IRWrite, RegWrite, WriteA, WriteB,
                WriteALUOut, ALUSrcA, ALUSrcB, ALUOp, PCSource, MemToReg, RegDst};

  logic [5:0] lw2_seq [10];

  multicycle_control #(.MEM_WAIT(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .PCWrite(PCWrite), .PCLoad(PCLoad), .SrcAddressMem(SrcAddressMem), .MemOp(MemOp),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .WriteA(WriteA), .WriteB(WriteB),
    .WriteALUOut(WriteALUOut), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .MemToReg(MemToReg), .RegDst(RegDst), .state_out(state_out),
    .exc_cause(exc_cause)
  );

  multicycle_control #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .reset(reset2), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .PCWrite(d2_PCWrite), .PCLoad(d2_PCLoad), .SrcAddressMem(d2_SrcAddressMem), .MemOp(d2_MemOp),
    .IRWrite(d2_IRWrite), .RegWrite(d2_RegWrite), .WriteA(d2_WriteA), .WriteB(d2_WriteB),
    .WriteALUOut(d2_WriteALUOut), .ALUSrcA(d2_ALUSrcA), .ALUSrcB(d2_ALUSrcB), .ALUOp(d2_ALUOp),
    .PCSource(d2_PCSource), .MemToReg(d2_MemToReg), .RegDst(d2_RegDst), .state_out(d2_state_out),
    .exc_cause(d2_exc_cause)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [27:0] exp;
    tick();
    tick();
    compared++;
    if ({state_out, ctl, exc_cause} !== {S_RESET, 28'd0, 2'd0}) begin
      $display("FAIL reset_state: got st=%0d ctl=%h exc=%0d want st=0 ctl=0 exc=0", state_out, ctl, exc_cause);
      mismatched++;
    end
    reset = 1'b0;
    tick();
    // FETCH: PCWrite, PCLoad, ALUSrcB=1, ALUOp=001, WriteALUOut
    exp = {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 3'b001, 2'd0, 3'd0, 3'd0};
    compared++;
    if ({state_out, ctl} !== {S_FETCH, exp}) begin
      $display("FAIL fetch_after_reset: got st=%0d ctl=%h want st=1 ctl=%h", state_out, ctl, exp);
      mismatched++;
    end
  endtask

  task automatic test_add();
    opcode = 6'h00; funct = 6'h20; overflow = 1'b0;
    tick();
    compared++;
    if ({state_out, SrcAddressMem, MemOp} !== {S_FWAIT, 3'd1, 1'b0}) begin
      $display("FAIL add_fwait: got %h want %h", {state_out, SrcAddressMem, MemOp}, {S_FWAIT, 3'd1, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, IRWrite, SrcAddressMem} !== {S_IRLOAD, 1'b1, 3'd1}) begin
      $display("FAIL add_irload: got %h want %h", {state_out, IRWrite, SrcAddressMem}, {S_IRLOAD, 1'b1, 3'd1});
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, WriteA, WriteB, WriteALUOut, ALUSrcA, ALUSrcB, ALUOp} !==
        {S_DECODE, 1'b1, 1'b1, 1'b1, 2'd0, 3'd3, 3'b001}) begin
      $display("FAIL add_decode: got %h want %h", {state_out, WriteA, WriteB, WriteALUOut, ALUSrcA, ALUSrcB, ALUOp},
               {S_DECODE, 1'b1, 1'b1, 1'b1, 2'd0, 3'd3, 3'b001});
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, ALUSrcA, ALUSrcB, ALUOp, WriteALUOut, RegWrite} !==
        {S_R_EX, 2'd1, 3'd0, 3'b001, 1'b1, 1'b0}) begin
      $display("FAIL add_rex: got %h want %h", {state_out, ALUSrcA, ALUSrcB, ALUOp, WriteALUOut, RegWrite},
               {S_R_EX, 2'd1, 3'd0, 3'b001, 1'b1, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, RegWrite, RegDst, MemToReg} !== {S_R_WB, 1'b1, 3'd1, 3'd0}) begin
      $display("FAIL add_rwb: got %h want %h", {state_out, RegWrite, RegDst, MemToReg}, {S_R_WB, 1'b1, 3'd1, 3'd0});
      mismatched++;
    end
    tick();
    compared++;
    if (state_out !== S_FETCH) begin
      $display("FAIL add_back_to_fetch: got st=%0d want st=%0d", state_out, S_FETCH);
      mismatched++;
    end
  endtask

  // sub, and, slt; overflow is raised for and/slt where it must be ignored.
  task automatic test_r_ops();
    logic [5:0] fn     [3] = '{6'h22, 6'h24, 6'h2A};
    logic [2:0] exp_op [3] = '{3'b010, 3'b011, 3'b111};
    logic [2:0] exp_m2r[3] = '{3'd0, 3'd0, 3'd2};
    logic       ovf    [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      opcode = 6'h00; funct = fn[i]; overflow = ovf[i];
      repeat (4) tick();
      compared++;
      if ({state_out, ALUOp} !== {S_R_EX, exp_op[i]}) begin
        $display("FAIL rop_ex[%0d]: got st=%0d op=%b want st=%0d op=%b", i, state_out, ALUOp, S_R_EX, exp_op[i]);
        mismatched++;
      end
      tick();
      compared++;
      if ({state_out, RegWrite, RegDst, MemToReg, exc_cause} !== {S_R_WB, 1'b1, 3'd1, exp_m2r[i], 2'd0}) begin
        $display("FAIL rop_wb[%0d]: got st=%0d rw=%0d rd=%0d m2r=%0d exc=%0d want st=%0d rw=1 rd=1 m2r=%0d exc=0",
                 i, state_out, RegWrite, RegDst, MemToReg, exc_cause, S_R_WB, exp_m2r[i]);
        mismatched++;
      end
      overflow = 1'b0;
      tick();
    end
    compared++;
    if (state_out !== S_FETCH) begin
      $display("FAIL rop_fetch: got st=%0d want st=%0d", state_out, S_FETCH);
      mismatched++;
    end
  endtask

  task automatic test_branch();
    logic [5:0] op   [3] = '{6'h04, 6'h04, 6'h05};
    logic       z    [3] = '{1'b1, 1'b0, 1'b0};
    logic       load [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      opcode = op[i];
      repeat (3) tick();
      zero = z[i];
      tick();
      compared++;
      if ({state_out, PCSource, ALUOp, ALUSrcA, PCWrite, PCLoad} !==
          {S_BRANCH, 2'd1, 3'b010, 2'd1, 1'b0, load[i]}) begin
        $display("FAIL branch[%0d]: got st=%0d src=%0d op=%b pcw=%0d pcl=%0d want st=%0d src=1 op=010 pcw=0 pcl=%0d",
                 i, state_out, PCSource, ALUOp, PCWrite, PCLoad, S_BRANCH, load[i]);
        mismatched++;
      end
      tick();
      zero = 1'b0;
      compared++;
      if (state_out !== S_FETCH) begin
        $display("FAIL branch_fetch[%0d]: got st=%0d want st=%0d", i, state_out, S_FETCH);
        mismatched++;
      end
    end
  endtask

  task automatic test_overflow();
    opcode = 6'h00; funct = 6'h20;
    repeat (4) tick();
    overflow = 1'b1;
    #1;
    compared++;
    if ({state_out, RegWrite} !== {S_R_EX, 1'b0}) begin
      $display("FAIL ovf_rex: got st=%0d rw=%0d want st=%0d rw=0", state_out, RegWrite, S_R_EX);
      mismatched++;
    end
    tick();
    overflow = 1'b0;
    compared++;
    if ({state_out, PCSource, PCWrite, PCLoad, RegWrite, exc_cause} !==
        {S_EXC, 2'd3, 1'b1, 1'b1, 1'b0, 2'd2}) begin
      $display("FAIL ovf_exc: got st=%0d src=%0d pcw=%0d pcl=%0d rw=%0d exc=%0d want st=%0d src=3 pcw=1 pcl=1 rw=0 exc=2",
               state_out, PCSource, PCWrite, PCLoad, RegWrite, exc_cause, S_EXC);
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, exc_cause} !== {S_FETCH, 2'd0}) begin
      $display("FAIL ovf_clear: got st=%0d exc=%0d want st=%0d exc=0", state_out, exc_cause, S_FETCH);
      mismatched++;
    end
  endtask

  task automatic test_bad_opcode();
    opcode = 6'h3F;
    repeat (3) tick();
    tick();
    compared++;
    if ({state_out, exc_cause, PCSource, PCWrite} !== {S_EXC, 2'd1, 2'd3, 1'b1}) begin
      $display("FAIL badop_exc: got st=%0d exc=%0d src=%0d pcw=%0d want st=%0d exc=1 src=3 pcw=1",
               state_out, exc_cause, PCSource, PCWrite, S_EXC);
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, exc_cause} !== {S_FETCH, 2'd0}) begin
      $display("FAIL badop_clear: got st=%0d exc=%0d want st=%0d exc=0", state_out, exc_cause, S_FETCH);
      mismatched++;
    end
  endtask

  task automatic test_sw();
    opcode = 6'h2B; overflow = 1'b1;
    repeat (4) tick();
    compared++;
    if ({state_out, ALUSrcA, ALUSrcB, ALUOp, MemOp} !== {S_ADDR, 2'd1, 3'd2, 3'b001, 1'b0}) begin
      $display("FAIL sw_addr: got %h want %h", {state_out, ALUSrcA, ALUSrcB, ALUOp, MemOp},
               {S_ADDR, 2'd1, 3'd2, 3'b001, 1'b0});
      mismatched++;
    end
    tick();
    overflow = 1'b0;
    compared++;
    if ({state_out, MemOp, SrcAddressMem, RegWrite} !== {S_SW, 1'b1, 3'd1, 1'b0}) begin
      $display("FAIL sw_write: got st=%0d memop=%0d src=%0d rw=%0d want st=%0d memop=1 src=1 rw=0",
               state_out, MemOp, SrcAddressMem, RegWrite, S_SW);
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, MemOp} !== {S_FETCH, 1'b0}) begin
      $display("FAIL sw_fetch: got st=%0d memop=%0d want st=%0d memop=0", state_out, MemOp, S_FETCH);
      mismatched++;
    end
  endtask

  // j, jr and lui are single-stage; addi has execute plus writeback.
  task automatic test_jumps_lui_addi();
    logic [5:0]  op  [3] = '{6'h02, 6'h00, 6'h0F};
    logic [5:0]  fn  [3] = '{6'h00, 6'h08, 6'h00};
    logic [5:0]  st  [3] = '{S_JUMP, S_JR, S_LUI};
    // {PCWrite, PCSource, RegWrite, MemToReg, ALUSrcA, ALUOp}
    logic [11:0] sig [3] = '{{1'b1, 2'd2, 1'b0, 3'd0, 2'd0, 3'd0},
                             {1'b1, 2'd0, 1'b0, 3'd0, 2'd1, 3'd0},
                             {1'b0, 2'd0, 1'b1, 3'd3, 2'd0, 3'd0}};
    for (int i = 0; i < 3; i++) begin
      opcode = op[i]; funct = fn[i];
      repeat (4) tick();
      compared++;
      if ({state_out, PCWrite, PCSource, RegWrite, MemToReg, ALUSrcA, ALUOp} !== {st[i], sig[i]}) begin
        $display("FAIL single_stage[%0d]: got %h want %h", i,
                 {state_out, PCWrite, PCSource, RegWrite, MemToReg, ALUSrcA, ALUOp}, {st[i], sig[i]});
        mismatched++;
      end
      tick();
    end
    opcode = 6'h08; funct = 6'h00;
    repeat (4) tick();
    compared++;
    if ({state_out, ALUSrcA, ALUSrcB, ALUOp, WriteALUOut} !== {S_I_EX, 2'd1, 3'd2, 3'b001, 1'b1}) begin
      $display("FAIL addi_ex: got %h want %h", {state_out, ALUSrcA, ALUSrcB, ALUOp, WriteALUOut},
               {S_I_EX, 2'd1, 3'd2, 3'b001, 1'b1});
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, RegWrite, RegDst, MemToReg} !== {S_I_WB, 1'b1, 3'd0, 3'd0}) begin
      $display("FAIL addi_wb: got %h want %h", {state_out, RegWrite, RegDst, MemToReg}, {S_I_WB, 1'b1, 3'd0, 3'd0});
      mismatched++;
    end
    tick();
    compared++;
    if (state_out !== S_FETCH) begin
      $display("FAIL addi_fetch: got st=%0d want st=%0d", state_out, S_FETCH);
      mismatched++;
    end
  endtask

  task automatic test_reset_mid_lw();
    opcode = 6'h23;
    repeat (5) tick();
    compared++;
    if (state_out !== S_MREAD) begin
      $display("FAIL midlw_mread: got st=%0d want st=%0d", state_out, S_MREAD);
      mismatched++;
    end
    reset = 1'b1;
    #1;
    compared++;
    if (ctl !== 28'd0) begin
      $display("FAIL midlw_reset_cycle: got ctl=%h want ctl=0", ctl);
      mismatched++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({state_out, ctl} !== {S_RESET, 28'd0}) begin
        $display("FAIL midlw_held[%0d]: got st=%0d ctl=%h want st=0 ctl=0", i, state_out, ctl);
        mismatched++;
      end
    end
    reset = 1'b0;
    opcode = 6'h02;
    #1;
    compared++;
    if ({state_out, RegWrite} !== {S_RESET, 1'b0}) begin
      $display("FAIL midlw_release: got st=%0d rw=%0d want st=0 rw=0", state_out, RegWrite);
      mismatched++;
    end
    tick();
    compared++;
    if ({state_out, RegWrite} !== {S_FETCH, 1'b0}) begin
      $display("FAIL midlw_fetch: got st=%0d rw=%0d want st=%0d rw=0", state_out, RegWrite, S_FETCH);
      mismatched++;
    end
  endtask

  // MEM_WAIT=2: two FWAIT states, then MREAD followed by two MWAIT states.
  task automatic test_lw_wait2();
    opcode = 6'h23;
    tick();
    compared++;
    if ({d2_state_out, d2_RegWrite} !== {S_RESET, 1'b0}) begin
      $display("FAIL lw2_reset: got st=%0d rw=%0d want st=0 rw=0", d2_state_out, d2_RegWrite);
      mismatched++;
    end
    reset2 = 1'b0;
    tick();
    compared++;
    if (d2_state_out !== S_FETCH) begin
      $display("FAIL lw2_fetch: got st=%0d want st=%0d", d2_state_out, S_FETCH);
      mismatched++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if (d2_state_out !== lw2_seq[i]) begin
        $display("FAIL lw2_seq[%0d]: got st=%0d want st=%0d", i, d2_state_out, lw2_seq[i]);
        mismatched++;
      end
      if (lw2_seq[i] == S_LW_WB) begin
        compared++;
        if ({d2_MemToReg, d2_RegWrite, d2_RegDst} !== {3'd1, 1'b1, 3'd0}) begin
          $display("FAIL lw2_wb: got m2r=%0d rw=%0d rd=%0d want m2r=1 rw=1 rd=0", d2_MemToReg, d2_RegWrite, d2_RegDst);
          mismatched++;
        end
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1; reset2 = 1'b1;
    opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
    lw2_seq = '{S_FWAIT, S_FWAIT, S_IRLOAD, S_DECODE, S_ADDR, S_MREAD, S_MWAIT, S_MWAIT, S_LW_WB, S_FETCH};
    test_reset();
    test_add();
    test_r_ops();
    test_branch();
    test_overflow();
    test_bad_opcode();
    test_sw();
    test_jumps_lui_addi();
    test_reset_mid_lw();
    test_lw_wait2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
